// File: rtl/vec_cfg_ctrl.sv
// Vector configuration sequencer: decodes vsetvli/vsetivli/vsetvl, computes vl from AVL and
// VLMAX, drains outstanding vector ops, writes the CSR regfile and returns vl to the core.
module vec_cfg_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned VLEN    = 512,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] cur_vl,
  input  logic            op_issue,
  input  logic            op_done,
  output logic            issue_stall,
  output logic            csrwr_en,
  output logic [XLEN-1:0] scalar2,
  output logic [XLEN-1:0] scalar1,
  input  logic            csr_done,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_vl,
  output logic [4:0]      resp_rd,
  output logic            resp_we,
  output logic            resp_illegal
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    WRITE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] vl_q;
  logic [7:0]      vtype_q;
  logic [4:0]      rd_q;
  logic            ill_q;

  logic            accept;
  logic            is_vli, is_vili, is_vl, fmt_ok;
  logic [7:0]      vtype_raw;
  logic            vtype_hi;
  logic [2:0]      vsew, vlmul;
  logic            legal;
  logic            use_x0_rule;
  logic [XLEN-1:0] avl;
  logic [XLEN-1:0] vlmax;
  logic [XLEN-1:0] new_vl;

  assign accept = cfg_valid && (state == IDLE);

  // Instruction decode and vl computation, evaluated combinationally on the accept cycle.
  always_comb begin
    is_vli      = (inst[31] == 1'b0);
    is_vili     = (inst[31:30] == 2'b11);
    is_vl       = (inst[31:25] == 7'b1000000);
    fmt_ok      = (inst[6:0] == 7'b1010111) && (inst[14:12] == 3'b111) &&
                  (is_vli || is_vili || is_vl);
    vtype_raw   = rs2_data[7:0];
    vtype_hi    = |rs2_data[XLEN-1:8];
    avl         = rs1_data;
    use_x0_rule = 1'b1;
    if (is_vili) begin
      vtype_raw   = inst[27:20];
      vtype_hi    = |inst[29:28];
      avl         = XLEN'(inst[19:15]);
      use_x0_rule = 1'b0;
    end else if (is_vli) begin
      vtype_raw = inst[27:20];
      vtype_hi  = |inst[30:28];
    end
    vsew  = vtype_raw[5:3];
    vlmul = vtype_raw[2:0];
    legal = fmt_ok && !vtype_hi && !vsew[2] && !vlmul[2];
    vlmax = (XLEN'(VLEN / 8) >> vsew[1:0]) << vlmul[1:0];
    if (use_x0_rule && (inst[19:15] == 5'd0)) begin
      if (inst[11:7] != 5'd0) new_vl = vlmax;
      else                    new_vl = (cur_vl < vlmax) ? cur_vl : vlmax;
    end else begin
      new_vl = (avl <= vlmax) ? avl : vlmax;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      count   <= '0;
      vl_q    <= '0;
      vtype_q <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_q    <= inst[11:7];
        ill_q   <= !legal;
        vl_q    <= legal ? new_vl : '0;
        vtype_q <= legal ? vtype_raw : '0;
      end
      // Saturating outstanding-op counter; a simultaneous issue and retire cancel out.
      unique case ({op_issue, op_done})
        2'b10:   if (count != CNT_MAX) count <= count + 1'b1;
        2'b01:   if (count != '0)      count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = legal ? DRAIN : RESP;
      DRAIN:   if (count == '0) state_nxt = WRITE;
      WRITE:   state_nxt = WAIT;
      WAIT:    if (csr_done) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready    = (state == IDLE);
    csrwr_en     = (state == WRITE);
    scalar1      = '0;
    scalar2      = '0;
    if ((state == WRITE) || (state == WAIT)) begin
      scalar1 = vl_q;
      scalar2 = XLEN'(vtype_q);
    end
    resp_valid   = (state == RESP);
    resp_vl      = (state == RESP) ? vl_q : '0;
    resp_rd      = (state == RESP) ? rd_q : '0;
    resp_we      = (state == RESP) && (rd_q != 5'd0) && !ill_q;
    resp_illegal = (state == RESP) && ill_q;
    issue_stall  = (state != IDLE) || (count == CNT_MAX) || (cfg_valid && (state == IDLE));
  end

endmodule

// File: tb/tb_vec_cfg_ctrl.sv
// Self-checking bench for vec_cfg_ctrl: vector table, multi-cycle corner sequences and
// randomized instructions checked against a plain-arithmetic reference model.
module tb_vec_cfg_ctrl;

  localparam int unsigned VLEN = 512;
  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] inst, rs1_data, rs2_data, cur_vl;
  logic        op_issue, op_done, issue_stall, csrwr_en, csr_done;
  logic [31:0] scalar1, scalar2, resp_vl;
  logic        resp_valid, resp_ready, resp_we, resp_illegal;
  logic [4:0]  resp_rd;

  vec_cfg_ctrl #(.XLEN(32), .VLEN(VLEN), .MAX_OUT(MAXO)) dut (
    .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .cur_vl(cur_vl),
    .op_issue(op_issue), .op_done(op_done), .issue_stall(issue_stall),
    .csrwr_en(csrwr_en), .scalar2(scalar2), .scalar1(scalar1), .csr_done(csr_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vl(resp_vl),
    .resp_rd(resp_rd), .resp_we(resp_we), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int model_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vili(input logic [4:0] rd, input logic [4:0] uimm,
                                           input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  // Reference: architectural vsetvl rules written directly with arithmetic.
  task automatic ref_cfg(input logic [31:0] ins, r1, r2, cv,
                         output logic ill, output logic [31:0] vl, output logic [7:0] vt);
    longint unsigned vtf, avl, vlmax, sew, lmul;
    bit x0_rule;
    ill = 1'b0; vl = '0; vt = '0; vtf = 0; avl = 0; x0_rule = 1'b0;
    if (ins[6:0] != 7'h57 || ins[14:12] != 3'd7) ill = 1'b1;
    else if (ins[31] == 1'b0) begin vtf = ins[30:20]; avl = r1; x0_rule = 1'b1; end
    else if (ins[31:30] == 2'b11) begin vtf = ins[29:20]; avl = ins[19:15]; end
    else if (ins[31:25] == 7'b1000000) begin vtf = r2; avl = r1; x0_rule = 1'b1; end
    else ill = 1'b1;
    sew  = (vtf / 8) % 8;
    lmul = vtf % 8;
    if (sew > 3 || lmul > 3 || vtf > 255) ill = 1'b1;
    if (!ill) begin
      vlmax = (VLEN / (8 * (2 ** sew))) * (2 ** lmul);
      if (x0_rule && ins[19:15] == 0) begin
        if (ins[11:7] != 0) vl = 32'(vlmax);
        else vl = (cv < vlmax) ? cv : 32'(vlmax);
      end else begin
        vl = (avl <= vlmax) ? 32'(avl) : 32'(vlmax);
      end
      vt = 8'(vtf);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    cfg_valid = 0; op_issue = 0; op_done = 0; csr_done = 0; resp_ready = 0;
    inst = '0; rs1_data = '0; rs2_data = '0; cur_vl = '0;
    model_cnt = 0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic ops(input bit iss, input bit dn, input int n);
    for (int i = 0; i < n; i++) begin
      op_issue = iss;
      op_done  = dn;
      tick();
      if (iss && !dn && model_cnt < MAXO) model_cnt++;
      if (dn && !iss && model_cnt > 0) model_cnt--;
    end
    op_issue = 0;
    op_done  = 0;
    #1;
    check("idle_stall", issue_stall, (model_cnt == MAXO));
  endtask

  // One full transaction: outstanding ops (model_cnt) are retired one per cycle from N+1.
  task automatic run_cfg(input string nm, input logic [31:0] ins, r1, r2, cv,
                         input logic eill, input logic [31:0] evl, input logic [7:0] evt,
                         input int hold);
    int cyc, cnt0, wrs;
    bit got, prev_wr;
    logic [31:0] svl;
    logic [4:0] erd;
    erd  = ins[11:7];
    cnt0 = model_cnt;
    inst = ins; rs1_data = r1; rs2_data = r2; cur_vl = cv;
    cfg_valid = 1; resp_ready = (hold == 0); op_done = 0; csr_done = 0;
    #1;
    check({nm, ".cfg_ready"}, cfg_ready, 1);
    check({nm, ".stall_req"}, issue_stall, 1);
    tick();
    cfg_valid = 0;
    got = 0; prev_wr = 0; wrs = 0; cyc = 1;
    while (!got && cyc <= 60) begin
      op_done  = !eill && (cyc <= cnt0);
      csr_done = prev_wr;
      #1;
      if (!issue_stall) check({nm, ".stall"}, issue_stall, 1);
      if (csrwr_en) begin
        wrs++;
        check({nm, ".wr_cycle"}, cyc, 2 + cnt0);
        check({nm, ".scalar1"}, scalar1, evl);
        check({nm, ".scalar2"}, scalar2, {24'd0, evt});
      end else if (prev_wr) begin
        check({nm, ".scalar1_hold"}, scalar1, evl);
      end
      prev_wr = csrwr_en;
      if (resp_valid) got = 1;
      else begin
        if (op_done && model_cnt > 0) model_cnt--;
        tick();
        cyc++;
      end
    end
    op_done = 0; csr_done = 0;
    check({nm, ".resp_seen"}, got, 1);
    if (!got) begin
      do_reset();
      return;
    end
    check({nm, ".resp_cycle"}, cyc, eill ? 1 : 4 + cnt0);
    check({nm, ".resp_vl"}, resp_vl, eill ? 32'd0 : evl);
    check({nm, ".resp_rd"}, resp_rd, erd);
    check({nm, ".resp_we"}, resp_we, !eill && (erd != 0));
    check({nm, ".resp_illegal"}, resp_illegal, eill);
    check({nm, ".csr_writes"}, wrs, eill ? 0 : 1);
    svl = resp_vl;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({nm, ".hold_valid"}, resp_valid, 1);
      check({nm, ".hold_vl"}, resp_vl, svl);
      check({nm, ".hold_ready"}, cfg_ready, 0);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    #1;
    check({nm, ".back_idle"}, cfg_ready, 1);
    check({nm, ".resp_clear"}, resp_valid, 0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] ins, r1, r2, cv;
    logic        ill;
    logic [31:0] vl;
    logic [7:0]  vt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic eill;
    logic [31:0] evl, ins, r1, r2, cv;
    logic [7:0] evt;

    tbl[0]  = '{"vli_e32m1",    enc_vli(5, 6, 11'h010),  100,          0,       0,   0, 16,  8'h10};
    tbl[1]  = '{"vili_e8m8",    enc_vili(1, 10, 10'h003), 0,           0,       0,   0, 10,  8'h03};
    tbl[2]  = '{"vli_x0_rd2",   enc_vli(2, 0, 11'h003),  5,            0,       0,   0, 512, 8'h03};
    tbl[3]  = '{"vli_x0_x0",    enc_vli(0, 0, 11'h018),  7,            0,       200, 0, 8,   8'h18};
    tbl[4]  = '{"sew5",         enc_vli(3, 4, 11'h028),  10,           0,       0,   1, 0,   8'h00};
    tbl[5]  = '{"lmul5",        enc_vli(3, 4, 11'h005),  10,           0,       0,   1, 0,   8'h00};
    tbl[6]  = '{"bad_opcode",   32'hC0357053,            10,           0,       0,   1, 0,   8'h00};
    tbl[7]  = '{"bad_funct3",   32'h00356057,            10,           0,       0,   1, 0,   8'h00};
    tbl[8]  = '{"vl_hibit",     enc_vl(4, 8, 9),         10,           32'h109, 0,   1, 0,   8'h00};
    tbl[9]  = '{"vli_zimm_hi",  enc_vli(4, 8, 11'h410),  10,           0,       0,   1, 0,   8'h00};
    tbl[10] = '{"vl_funct7",    32'h82940257,            10,           9,       0,   1, 0,   8'h00};
    tbl[11] = '{"avl_eq_max",   enc_vli(6, 7, 11'h000),  64,           0,       0,   0, 64,  8'h00};
    tbl[12] = '{"avl_max_p1",   enc_vli(6, 7, 11'h000),  65,           0,       0,   0, 64,  8'h00};
    tbl[13] = '{"vili_zero_x0", enc_vili(0, 0, 10'h000),  0,           0,       0,   0, 0,   8'h00};
    tbl[14] = '{"vtavma_big",   enc_vli(8, 9, 11'h0C0),  32'hFFFFFFFF, 0,       0,   0, 64,  8'hC0};

    // Reset state
    n_rst = 1'b0;
    cfg_valid = 0; op_issue = 0; op_done = 0; csr_done = 0; resp_ready = 0;
    inst = '0; rs1_data = '0; rs2_data = '0; cur_vl = '0;
    #3;
    check("rst.cfg_ready", cfg_ready, 1);
    check("rst.csrwr_en", csrwr_en, 0);
    check("rst.scalar1", scalar1, 0);
    check("rst.scalar2", scalar2, 0);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_vl", resp_vl, 0);
    check("rst.resp_rd", resp_rd, 0);
    check("rst.resp_we", resp_we, 0);
    check("rst.resp_illegal", resp_illegal, 0);
    check("rst.issue_stall", issue_stall, 0);
    do_reset();

    for (int i = 0; i < 15; i++)
      run_cfg(tbl[i].nm, tbl[i].ins, tbl[i].r1, tbl[i].r2, tbl[i].cv,
              tbl[i].ill, tbl[i].vl, tbl[i].vt, 0);

    // Drain three outstanding ops before a vsetvl e16,m2 (VLMAX 64)
    ops(1, 0, 3);
    run_cfg("drain3", enc_vl(7, 8, 9), 1000, 32'h09, 0, 0, 64, 8'h09, 0);

    // Counter saturation / no underflow, then a held response
    ops(1, 0, 10);
    ops(1, 1, 2);
    ops(0, 1, 1);
    ops(0, 1, 8);
    ops(1, 1, 1);
    ops(0, 1, 2);
    run_cfg("hold5", enc_vli(9, 10, 11'h00A), 50, 0, 0, 0, 50, 8'h0A, 5);

    // Reset while waiting for csr_done, with one op issued meanwhile
    inst = enc_vli(5, 6, 11'h010); rs1_data = 100; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    tick();
    check("rstw.wr", csrwr_en, 1);
    op_issue = 1;
    tick();
    op_issue = 0;
    check("rstw.wait_s1", scalar1, 16);
    n_rst = 1'b0;
    #1;
    check("rstw.cfg_ready", cfg_ready, 1);
    check("rstw.scalar1", scalar1, 0);
    check("rstw.scalar2", scalar2, 0);
    check("rstw.csrwr_en", csrwr_en, 0);
    check("rstw.resp_valid", resp_valid, 0);
    check("rstw.stall", issue_stall, 0);
    tick();
    n_rst = 1'b1;
    model_cnt = 0;
    tick();
    run_cfg("after_rst", enc_vli(5, 6, 11'h010), 100, 0, 0, 0, 16, 8'h10, 0);

    // Randomized instructions against the reference model
    for (int it = 0; it < 60; it++) begin
      logic [4:0] rd, rs1f;
      logic [7:0] vt8;
      logic [2:0] hi;
      int kind;
      ops(1, 0, $urandom_range(0, 3));
      kind = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      vt8  = {2'($urandom), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
      hi   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      case ($urandom_range(0, 2))
        0:       r1 = $urandom_range(0, 600);
        1:       r1 = $urandom;
        default: r1 = 32'(8 << $urandom_range(0, 6));
      endcase
      r2 = '0;
      cv = $urandom_range(0, 600);
      case (kind)
        0: ins = enc_vli(rd, rs1f, {hi, vt8});
        1: ins = enc_vili(rd, rs1f, {hi[1:0], vt8});
        2: begin
          ins = enc_vl(rd, rs1f, 5'($urandom));
          r2 = {(hi != 0) ? 24'($urandom) : 24'd0, vt8};
        end
        default: begin
          ins = $urandom;
          if ($urandom_range(0, 1) == 1) ins[6:0] = 7'h57;
        end
      endcase
      ref_cfg(ins, r1, r2, cv, eill, evl, evt);
      run_cfg("rand", ins, r1, r2, cv, eill, evl, evt, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
